result_drain: RTL and testbench

RESULT_DRAIN -- requirements
Module: result_drain

---
 rtl/result_drain.sv | 136 +++++++++++++
 tb/tb_result_drain.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/result_drain.sv
// Collects a full matrix of result blocks from the accumulator, then streams
// them to the host in block index order over a valid/ready drain port.
module result_drain #(
  parameter int WIDTH          = 16,
  parameter int CHUNK_SIZE     = 4,
  parameter int ROW_SIZE_MAT_C = 3,
  parameter int COL_SIZE_MAT_C = 3,
  localparam int DW            = WIDTH * CHUNK_SIZE,
  localparam int MAX_FLAG      = ROW_SIZE_MAT_C * COL_SIZE_MAT_C,
  localparam int AW            = (MAX_FLAG > 1) ? $clog2(MAX_FLAG) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          start,
  output logic          ready,
  output logic          done,
  output logic          err,
  input  logic          acc_valid,
  input  logic [DW-1:0] acc_data,
  output logic          acc_ready,
  output logic [AW-1:0] blk_row,
  output logic [AW-1:0] blk_col,
  output logic          out_valid,
  output logic [DW-1:0] out_data,
  output logic          out_last,
  input  logic          out_ready
);

  localparam logic [AW-1:0] LAST_IDX = AW'(MAX_FLAG - 1);
  localparam logic [AW-1:0] LAST_COL = AW'(COL_SIZE_MAT_C - 1);

  typedef enum logic [1:0] {IDLE, COLLECT, DRAIN, DONE} state_t;

  state_t        state, next_state;
  logic [DW-1:0] mem [MAX_FLAG];
  logic [AW-1:0] wr_addr;
  logic [AW-1:0] rd_idx;
  logic          accept;
  logic          last_blk;
  logic          drain_end;

  assign wr_addr   = AW'(int'(blk_row) * COL_SIZE_MAT_C + int'(blk_col));
  assign accept    = (state == COLLECT) && acc_valid && !clr;
  assign last_blk  = accept && (wr_addr == LAST_IDX);
  assign drain_end = (state == DRAIN) && out_valid && out_ready && out_last;
  assign acc_ready = (state == COLLECT);
  assign ready     = (state == IDLE) || (state == DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    if (clr) begin
      next_state = IDLE;
    end else begin
      case (state)
        IDLE, DONE: if (start)     next_state = COLLECT;
        COLLECT:    if (last_blk)  next_state = DRAIN;
        DRAIN:      if (drain_end) next_state = DONE;
        default:                   next_state = IDLE;
      endcase
    end
  end

  // Storage is deliberately left out of reset so it maps onto plain RAM.
  always_ff @(posedge clk) begin
    if (accept) mem[wr_addr] <= acc_data;
  end

  // A new drain word is fetched whenever the output register is empty or
  // being consumed, which gives one word per cycle once the pipe is primed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      blk_row   <= '0;
      blk_col   <= '0;
      rd_idx    <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else if (clr) begin
      blk_row   <= '0;
      blk_col   <= '0;
      rd_idx    <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      done <= drain_end;
      if (acc_valid && (state != COLLECT)) err <= 1'b1;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            blk_row   <= '0;
            blk_col   <= '0;
            rd_idx    <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
          end
        end
        COLLECT: begin
          if (accept) begin
            if (last_blk) begin
              blk_row <= '0;
              blk_col <= '0;
            end else if (blk_col == LAST_COL) begin
              blk_col <= '0;
              blk_row <= blk_row + 1'b1;
            end else begin
              blk_col <= blk_col + 1'b1;
            end
          end
        end
        DRAIN: begin
          if (drain_end) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
          end else if (!out_valid || out_ready) begin
            out_valid <= 1'b1;
            out_data  <= mem[rd_idx];
            out_last  <= (rd_idx == LAST_IDX);
            rd_idx    <= rd_idx + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_result_drain.sv
// Scoreboard bench for result_drain: blocks pushed to an expected queue on
// issue, a free-running monitor pops and compares each drained word.
module tb_result_drain;

  localparam int WIDTH    = 16;
  localparam int CHUNK    = 4;
  localparam int ROWS     = 3;
  localparam int COLS     = 3;
  localparam int DW       = WIDTH * CHUNK;
  localparam int MAX_FLAG = ROWS * COLS;
  localparam int AW       = (MAX_FLAG > 1) ? $clog2(MAX_FLAG) : 1;

  logic          clk = 1'b0;
  logic          rst, clr, start, acc_valid, out_ready;
  logic [DW-1:0] acc_data;
  logic          ready, done, err, acc_ready, out_valid, out_last;
  logic [AW-1:0] blk_row, blk_col;
  logic [DW-1:0] out_data;

  typedef struct {
    logic [DW-1:0] data;
    logic          last;
  } exp_t;

  exp_t exp_q[$];
  int   push_idx   = 0;
  int   ready_mode = 0;
  int   total      = 0;
  int   bad        = 0;

  result_drain #(
    .WIDTH(WIDTH), .CHUNK_SIZE(CHUNK),
    .ROW_SIZE_MAT_C(ROWS), .COL_SIZE_MAT_C(COLS)
  ) dut (
    .clk(clk), .rst(rst), .clr(clr), .start(start),
    .ready(ready), .done(done), .err(err),
    .acc_valid(acc_valid), .acc_data(acc_data), .acc_ready(acc_ready),
    .blk_row(blk_row), .blk_col(blk_col),
    .out_valid(out_valid), .out_data(out_data), .out_last(out_last),
    .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [DW-1:0] act,
                             input logic [DW-1:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("[TB] FAIL %s: actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Host backpressure: 0 = always ready, 1 = alternate 1010.., 2 = random.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        1:       out_ready = ~out_ready;
        2:       out_ready = 1'($urandom_range(0, 1));
        default: out_ready = 1'b1;
      endcase
    end
  end

  // Monitor: handshakes are judged at the falling edge, where inputs are
  // settled for the coming rising edge.
  initial begin : monitor
    bit            hold = 1'b0;
    logic [DW-1:0] held_data;
    logic          held_last;
    exp_t          e;
    forever begin
      @(negedge clk);
      if (rst || clr) begin
        hold = 1'b0;
      end else if (out_valid) begin
        if (hold) begin
          checkOutput("stall_data", out_data, held_data);
          checkOutput("stall_last", DW'(out_last), DW'(held_last));
        end
        if (out_ready) begin
          if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("[TB] FAIL unexpected_word: actual=%0h required=none", out_data);
          end else begin
            e = exp_q.pop_front();
            checkOutput("drain_data", out_data, e.data);
            checkOutput("drain_last", DW'(out_last), DW'(e.last));
          end
          hold = 1'b0;
        end else begin
          hold      = 1'b1;
          held_data = out_data;
          held_last = out_last;
        end
      end else if (hold) begin
        total++;
        bad++;
        $display("[TB] FAIL valid_drop: actual=0 required=1");
        hold = 1'b0;
      end
    end
  end

  // One block beat, optionally preceded by idle cycles; the model's expected
  // drain order is simply arrival order.
  task automatic applyStimulus(input logic [DW-1:0] d, input int gap);
    exp_t e;
    repeat (gap) tick();
    acc_valid = 1'b1;
    acc_data  = d;
    e.data    = d;
    e.last    = (push_idx == MAX_FLAG - 1);
    exp_q.push_back(e);
    push_idx++;
    tick();
    acc_valid = 1'b0;
  endtask

  task automatic start_pass();
    start = 1'b1;
    tick();
    start    = 1'b0;
    push_idx = 0;
    checkOutput("acc_ready_collect", DW'(acc_ready), 1);
    checkOutput("ready_busy", DW'(ready), 0);
  endtask

  task automatic send_blocks(input int n, input bit directed, input bit gaps,
                             input bit coord_check);
    logic [DW-1:0] d;
    for (int k = 1; k <= n; k++) begin
      d = directed ? DW'(k) : {$urandom, $urandom};
      applyStimulus(d, gaps ? int'($urandom_range(0, 2)) : 0);
      if (coord_check) begin
        checkOutput("blk_row", DW'(blk_row), (k == MAX_FLAG) ? 0 : DW'(k / COLS));
        checkOutput("blk_col", DW'(blk_col), (k == MAX_FLAG) ? 0 : DW'(k % COLS));
      end
    end
  endtask

  task automatic wait_done(input int budget);
    bit seen = 1'b0;
    int n    = 0;
    while (n < budget && !seen) begin
      @(negedge clk);
      if (done) seen = 1'b1;
      n++;
    end
    checkOutput("done_seen", DW'(seen), 1);
    checkOutput("no_loss", DW'(exp_q.size()), 0);
    checkOutput("valid_in_done", DW'(out_valid), 0);
    @(negedge clk);
    checkOutput("done_one_cycle", DW'(done), 0);
    checkOutput("ready_after_done", DW'(ready), 1);
  endtask

  task automatic full_pass(input bit gaps);
    start_pass();
    send_blocks(MAX_FLAG, 1'b0, gaps, 1'b0);
    wait_done(200);
    tick();
  endtask

  initial begin : watchdog
    #200000;
    $display("[TB] FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "[TB] simulation timeout");
  end

  initial begin
    rst = 1'b0; clr = 1'b0; start = 1'b0;
    acc_valid = 1'b0; acc_data = '0; out_ready = 1'b0;
    #1 rst = 1'b1;
    #1;
    checkOutput("rst_ready", DW'(ready), 1);
    checkOutput("rst_acc_ready", DW'(acc_ready), 0);
    checkOutput("rst_out_valid", DW'(out_valid), 0);
    checkOutput("rst_out_last", DW'(out_last), 0);
    checkOutput("rst_out_data", out_data, 0);
    checkOutput("rst_done", DW'(done), 0);
    checkOutput("rst_err", DW'(err), 0);
    checkOutput("rst_blk_row", DW'(blk_row), 0);
    checkOutput("rst_blk_col", DW'(blk_col), 0);
    tick();
    tick();
    rst = 1'b0;
    tick();

    $display("[TB] directed pass, consecutive blocks, host always ready");
    ready_mode = 0;
    start_pass();
    send_blocks(MAX_FLAG, 1'b1, 1'b0, 1'b1);
    checkOutput("drain_entry_valid", DW'(out_valid), 0);
    @(negedge clk);
    checkOutput("drain_latency", DW'(out_valid), 0);
    for (int i = 0; i < MAX_FLAG; i++) begin
      @(negedge clk);
      checkOutput("no_bubble", DW'(out_valid), 1);
    end
    @(negedge clk);
    checkOutput("done_pulse", DW'(done), 1);
    checkOutput("done_valid_low", DW'(out_valid), 0);
    @(negedge clk);
    checkOutput("done_cleared", DW'(done), 0);
    checkOutput("done_ready", DW'(ready), 1);
    checkOutput("directed_no_loss", DW'(exp_q.size()), 0);
    tick();

    $display("[TB] acc_valid while idle");
    clr = 1'b1;
    tick();
    clr = 1'b0;
    acc_valid = 1'b1;
    acc_data  = {$urandom, $urandom};
    checkOutput("idle_acc_ready", DW'(acc_ready), 0);
    tick();
    acc_valid = 1'b0;
    checkOutput("err_set", DW'(err), 1);
    repeat (3) tick();
    checkOutput("err_sticky", DW'(err), 1);
    full_pass(1'b0);
    checkOutput("err_sticky_pass", DW'(err), 1);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    checkOutput("err_cleared", DW'(err), 0);

    $display("[TB] random passes with gaps and backpressure");
    ready_mode = 1;
    full_pass(1'b1);
    ready_mode = 2;
    full_pass(1'b1);
    full_pass(1'b1);

    $display("[TB] clr with start mid-drain");
    ready_mode = 0;
    tick();
    start_pass();
    send_blocks(MAX_FLAG, 1'b0, 1'b0, 1'b0);
    repeat (5) tick();
    checkOutput("mid_drain_valid", DW'(out_valid), 1);
    clr   = 1'b1;
    start = 1'b1;
    tick();
    clr   = 1'b0;
    start = 1'b0;
    checkOutput("clr_out_valid", DW'(out_valid), 0);
    checkOutput("clr_idle_ready", DW'(ready), 1);
    checkOutput("clr_idle_acc_ready", DW'(acc_ready), 0);
    exp_q.delete();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("clr_no_done", DW'(done), 0);
    end
    tick();
    full_pass(1'b0);

    $display("[TB] async reset mid-collect");
    start_pass();
    send_blocks(4, 1'b0, 1'b0, 1'b0);
    #2 rst = 1'b1;
    #1;
    checkOutput("arst_blk_row", DW'(blk_row), 0);
    checkOutput("arst_blk_col", DW'(blk_col), 0);
    checkOutput("arst_acc_ready", DW'(acc_ready), 0);
    checkOutput("arst_ready", DW'(ready), 1);
    checkOutput("arst_out_valid", DW'(out_valid), 0);
    checkOutput("arst_err", DW'(err), 0);
    exp_q.delete();
    tick();
    rst = 1'b0;
    tick();
    ready_mode = 2;
    full_pass(1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
